// File: rtl/prime_trial_checker.sv
// prime_trial_checker
// Decides whether a candidate number is prime by trial division, where each
// division is done by repeated subtraction (no hardware divider), and compares
// the verdict with player 2's guess.
//
// Ports:
//   clk      - system clock, rising edge
//   rst      - asynchronous active-low reset
//   start    - request pulse, sampled only while idle
//   num      - candidate number, captured when start is accepted
//   guess    - player 2 claim (1 = prime), captured when start is accepted
//   busy     - high while a check is in progress
//   done     - one-cycle registered pulse, result valid
//   is_prime - primality result, held until the next done
//   match    - (is_prime == captured guess), held until the next done
module prime_trial_checker #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] num,
  input  logic             guess,
  output logic             busy,
  output logic             done,
  output logic             is_prime,
  output logic             match
);

  typedef enum logic [1:0] {StIdle, StCheck, StSub} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] n_q, n_d;
  logic [WIDTH-1:0] d_q, d_d;
  logic [WIDTH-1:0] r_q, r_d;
  logic             guess_q, guess_d;
  logic             done_q, done_d;
  logic             is_prime_q, is_prime_d;
  logic             match_q, match_d;

  // Full-width square so d*d > n never truncates.
  logic [2*WIDTH-1:0] d_sq;
  logic [2*WIDTH-1:0] n_ext;

  assign d_sq  = {{WIDTH{1'b0}}, d_q} * {{WIDTH{1'b0}}, d_q};
  assign n_ext = {{WIDTH{1'b0}}, n_q};

  always_comb begin
    state_d    = state_q;
    n_d        = n_q;
    d_d        = d_q;
    r_d        = r_q;
    guess_d    = guess_q;
    done_d     = 1'b0;
    is_prime_d = is_prime_q;
    match_d    = match_q;

    case (state_q)
      StIdle: begin
        if (start) begin
          n_d     = num;
          guess_d = guess;
          if (num < WIDTH'(2)) begin
            done_d     = 1'b1;
            is_prime_d = 1'b0;
            match_d    = ~guess;
          end else if (num < WIDTH'(4)) begin
            done_d     = 1'b1;
            is_prime_d = 1'b1;
            match_d    = guess;
          end else begin
            d_d     = WIDTH'(2);
            state_d = StCheck;
          end
        end
      end

      StCheck: begin
        if (d_sq > n_ext) begin
          // No divisor up to sqrt(n): prime.
          done_d     = 1'b1;
          is_prime_d = 1'b1;
          match_d    = guess_q;
          state_d    = StIdle;
        end else begin
          r_d     = n_q;
          state_d = StSub;
        end
      end

      StSub: begin
        if (r_q == '0) begin
          // d divides n exactly: composite.
          done_d     = 1'b1;
          is_prime_d = 1'b0;
          match_d    = ~guess_q;
          state_d    = StIdle;
        end else if (r_q < d_q) begin
          d_d     = d_q + WIDTH'(1);
          state_d = StCheck;
        end else begin
          r_d = r_q - d_q;
        end
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= StIdle;
      n_q        <= '0;
      d_q        <= '0;
      r_q        <= '0;
      guess_q    <= 1'b0;
      done_q     <= 1'b0;
      is_prime_q <= 1'b0;
      match_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      n_q        <= n_d;
      d_q        <= d_d;
      r_q        <= r_d;
      guess_q    <= guess_d;
      done_q     <= done_d;
      is_prime_q <= is_prime_d;
      match_q    <= match_d;
    end
  end

  assign busy     = (state_q != StIdle);
  assign done     = done_q;
  assign is_prime = is_prime_q;
  assign match    = match_q;

endmodule

// File: tb/tb_prime_trial_checker.sv
// Scoreboard bench for prime_trial_checker: the driver pushes the expected
// result of every accepted request; a monitor pops and compares on each done.
module tb_prime_trial_checker;

  localparam int unsigned WIDTH = 8;
  localparam int TIMEOUT = 3000;

  logic             clk;
  logic             rst;
  logic             start;
  logic [WIDTH-1:0] num;
  logic             guess;
  logic             busy;
  logic             done;
  logic             is_prime;
  logic             match;

  prime_trial_checker #(.WIDTH(WIDTH)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .num      (num),
    .guess    (guess),
    .busy     (busy),
    .done     (done),
    .is_prime (is_prime),
    .match    (match)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int   n;
    logic ip;
    logic m;
    int   lat;
    int   acc;
  } exp_t;

  exp_t exp_q[$];
  int   cyc = 0;
  int   total = 0;
  int   passed = 0;
  int   accepted = 0;
  int   done_cnt = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int expv);
    total++;
    if (act == expv) passed++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, expv, $time);
  endtask

  // Reference: plain definition of primality.
  function automatic logic ref_prime(input int n);
    if (n < 2) return 1'b0;
    for (int k = 2; k < n; k++) if (n % k == 0) return 1'b0;
    return 1'b1;
  endfunction

  // Monitor
  always @(negedge clk) begin
    if (rst && done) begin
      done_cnt++;
      if (exp_q.size() == 0) begin
        chk("unexpected_done", 1, 0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk($sformatf("is_prime(n=%0d)", e.n), int'(is_prime), int'(e.ip));
        chk($sformatf("match(n=%0d)", e.n), int'(match), int'(e.m));
        if (e.lat >= 0) chk($sformatf("latency(n=%0d)", e.n), cyc - e.acc, e.lat);
      end
    end
  end

  // Waits until idle, presents a request for one edge, records expectation.
  task automatic issue(input int n, input logic g, input int lat);
    int t = 0;
    while (busy && t < TIMEOUT) begin
      @(posedge clk);
      #1;
      t++;
    end
    if (busy) chk("idle_timeout", 1, 0);
    start = 1'b1;
    num   = WIDTH'(n);
    guess = g;
    @(posedge clk);
    #1;
    start = 1'b0;
    begin
      exp_t e;
      e.n   = n;
      e.ip  = ref_prime(n);
      e.m   = (ref_prime(n) == g);
      e.lat = (n < 4) ? 0 : lat;
      e.acc = cyc;
      exp_q.push_back(e);
    end
    accepted++;
  endtask

  initial begin
    rst   = 1'b0;
    start = 1'b0;
    num   = '0;
    guess = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_busy", int'(busy), 0);
    chk("reset_done", int'(done), 0);
    chk("reset_is_prime", int'(is_prime), 0);
    chk("reset_match", int'(match), 0);
    rst = 1'b1;
    @(posedge clk);
    #1;

    // Abort a long check mid-SUB with an asynchronous reset.
    issue(200, 1'b0, -1);
    repeat (10) @(posedge clk);
    #3;
    chk("pre_abort_busy", int'(busy), 1);
    rst = 1'b0;
    #1;
    chk("abort_busy", int'(busy), 0);
    chk("abort_done", int'(done), 0);
    chk("abort_is_prime", int'(is_prime), 0);
    chk("abort_match", int'(match), 0);
    void'(exp_q.pop_back());
    accepted--;
    @(posedge clk);
    #1;
    rst = 1'b1;
    issue(7, 1'b1, -1);

    for (int i = 0; i < 4; i++) issue(i, 1'b1, 0);

    // n = 4: busy for exactly four cycles, done at E+4.
    issue(4, 1'b0, 4);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk($sformatf("busy_n4_cycle%0d", i), int'(busy), 1);
    end
    @(negedge clk);
    chk("busy_n4_cycle3", int'(busy), 1);
    @(negedge clk);
    chk("busy_n4_after", int'(busy), 0);

    issue(5, 1'b0, 5);
    issue(251, 1'b1, -1);
    issue(255, 1'b1, -1);
    issue(169, 1'b0, -1);

    // Start pulses while busy must be ignored.
    issue(97, 1'b1, -1);
    start = 1'b1;
    num   = 8'd9;
    guess = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    start = 1'b0;

    for (int i = 0; i < 256; i++) issue(i, 1'($urandom_range(0, 1)), -1);
    for (int i = 0; i < 30; i++) issue(int'($urandom_range(0, 255)), 1'($urandom_range(0, 1)), -1);

    begin
      int t = 0;
      while (exp_q.size() != 0 && t < TIMEOUT) begin
        @(posedge clk);
        t++;
      end
      chk("pending_at_end", exp_q.size(), 0);
    end
    repeat (5) @(posedge clk);
    #1;
    chk("done_count", done_cnt, accepted);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
